// File: rtl/chart_pkg.sv
// Chart recorder shared types and constants.
// Entry layout matches the chart playback reader.
package chart_pkg;

  localparam int ADDR_W   = 7;
  localparam int ARROWS_W = 4;
  localparam int TIMING_W = 4;
  localparam int MAX_GAP  = 2**TIMING_W - 1;

  localparam logic [7:0] END_MARKER = 8'h00;
  localparam logic [7:0] FILLER     = 8'h0F;

  typedef enum logic [1:0] {
    IDLE,
    RECORD,
    FLUSH,
    DONE
  } state_e;

  typedef struct packed {
    logic [ARROWS_W-1:0] arrows;
    logic [TIMING_W-1:0] timing;
  } chart_entry_t;

endpackage

// File: rtl/arrow_edge_acc.sv
// Rising-edge detector with sticky OR accumulator.
// acc_now includes presses seen in the current cycle.
module arrow_edge_acc #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] arrows,
  output logic [W-1:0] acc_now
);

  logic [W-1:0] prev;
  logic [W-1:0] acc;

  assign acc_now = acc | (arrows & ~prev);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= '0;
      acc  <= '0;
    end else begin
      prev <= arrows;
      if (load) begin
        acc <= '0;
      end else if (en) begin
        acc <= clr ? '0 : acc_now;
      end
    end
  end

endmodule

// File: rtl/chart_recorder.sv
// Records live arrow presses into chart RAM as
// {arrows, timing} entries with an end marker.
module chart_recorder #(
  parameter int ADDR_W   = chart_pkg::ADDR_W,
  parameter int ARROWS_W = chart_pkg::ARROWS_W,
  parameter int TIMING_W = chart_pkg::TIMING_W
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic                         stop_i,
  input  logic                         tick_i,
  input  logic [ARROWS_W-1:0]          arrows_i,
  output logic                         wr_en_o,
  output logic [ADDR_W-1:0]            wr_addr_o,
  output logic [ARROWS_W+TIMING_W-1:0] wr_data_o,
  output logic [ADDR_W:0]              len_o,
  output logic                         busy_o,
  output logic                         done_o
);

  import chart_pkg::*;

  localparam int DW = ARROWS_W + TIMING_W;
  localparam logic [TIMING_W-1:0] GAP_MAX = '1;
  localparam logic [ADDR_W-1:0] LAST = '1;

  state_e state;
  state_e state_n;

  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     len;
  logic [TIMING_W-1:0] gap;
  logic [TIMING_W-1:0] gap_n;
  logic [TIMING_W-1:0] g;
  logic [ARROWS_W-1:0] acc_now;
  logic [DW-1:0]       data;
  logic rec;
  logic full;
  logic load;
  logic wr;
  logic clr;

  assign rec  = (state == RECORD);
  assign full = (addr == LAST);
  assign g    = gap + 1'b1;
  assign load = start_i && (state == IDLE || state == DONE);

  arrow_edge_acc #(
    .W(ARROWS_W)
  ) u_acc (
    .clk    (clk_i),
    .rst_n  (reset_i),
    .load   (load),
    .en     (rec),
    .clr    (clr),
    .arrows (arrows_i),
    .acc_now(acc_now)
  );

  always_comb begin
    state_n = state;
    gap_n   = gap;
    wr      = 1'b0;
    clr     = 1'b0;
    data    = '0;
    unique case (state)
      IDLE, DONE: begin
        if (start_i) state_n = RECORD;
      end
      RECORD: begin
        if (stop_i || full) state_n = FLUSH;
        // the last slot is reserved for the end marker
        if (tick_i && !full) begin
          if (acc_now != '0) begin
            wr    = 1'b1;
            clr   = 1'b1;
            data  = {acc_now, g};
            gap_n = '0;
          end else if (g == GAP_MAX) begin
            wr    = 1'b1;
            data  = {{ARROWS_W{1'b0}}, GAP_MAX};
            gap_n = '0;
          end else begin
            gap_n = g;
          end
        end
      end
      FLUSH: begin
        state_n = DONE;
        wr      = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state     <= IDLE;
      addr      <= '0;
      len       <= '0;
      gap       <= '0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      state   <= state_n;
      gap     <= gap_n;
      wr_en_o <= wr;
      if (load) begin
        addr <= '0;
        len  <= '0;
        gap  <= '0;
      end
      if (wr) begin
        wr_addr_o <= addr;
        wr_data_o <= data;
        len       <= len + 1'b1;
        if (rec) addr <= addr + 1'b1;
      end
    end
  end

  assign len_o  = len;
  assign busy_o = (state == RECORD) || (state == FLUSH);
  assign done_o = (state == DONE);

endmodule

// File: tb/tb_chart_recorder.sv
// Scoreboard bench for chart_recorder.
// Expected writes are queued as stimulus is driven.
module tb_chart_recorder;

  import chart_pkg::*;

  typedef struct {
    int         cyc;
    logic [6:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic       tick;
  logic [3:0] arrows;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] len;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  chart_recorder dut (
    .clk_i    (clk),
    .reset_i  (reset_n),
    .start_i  (start),
    .stop_i   (stop),
    .tick_i   (tick),
    .arrows_i (arrows),
    .wr_en_o  (wr_en),
    .wr_addr_o(wr_addr),
    .wr_data_o(wr_data),
    .len_o    (len),
    .busy_o   (busy),
    .done_o   (done)
  );

  task automatic expect_wr(input int c, input int a, input logic [7:0] d);
    exp_t e;
    e.cyc  = c;
    e.addr = 7'(a);
    e.data = d;
    sb.push_back(e);
  endtask

  // advance one clock; pop the scoreboard on every RAM write
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (wr_en === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected: got addr %0d data %02h cyc %0d, required no write",
                 wr_addr, wr_data, cyc);
      end else begin
        e = sb.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data || cyc != e.cyc) begin
          fails++;
          $display("FAIL wr_entry: got addr %0d data %02h cyc %0d, required addr %0d data %02h cyc %0d",
                   wr_addr, wr_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0; stop = 1'b0; tick = 1'b0; arrows = 4'h0;
    step();
    step();
    tests++;
    if ({wr_en, wr_addr, wr_data, len, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got en %b addr %0d data %02h len %0d busy %b done %b, required all 0",
               wr_en, wr_addr, wr_data, len, busy, done);
    end
    reset_n = 1'b1;
    stop = 1'b1; tick = 1'b1; arrows = 4'hF;
    step();
    step();
    arrows = 4'h0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_ignores: got busy %b done %b, required 0 0", busy, done);
    end
  endtask

  task automatic test_single_press();
    start = 1'b1;
    step();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL start_busy: got %b, required 1", busy);
    end
    for (int k = 1; k <= 3; k++) begin
      tick = 1'b1;
      step();
      step();
    end
    arrows = 4'b0001;
    step();
    tick = 1'b1;
    expect_wr(cyc + 1, 0, 8'h14);
    step();
    step();
    tick = 1'b1;
    step();
    stop = 1'b1;
    expect_wr(cyc + 2, 1, END_MARKER);
    step();
    arrows = 4'h0;
    for (int i = 0; i < 8 && sb.size() != 0; i++) step();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL single_drain: %0d writes missing, required 0", sb.size());
      sb.delete();
    end
    tests++;
    if (len !== 8'd2 || done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_status: got len %0d done %b busy %b, required 2 1 0", len, done, busy);
    end
  endtask

  task automatic test_filler();
    start = 1'b1;
    step();
    for (int k = 1; k <= 31; k++) begin
      tick = 1'b1;
      if (k == 15) expect_wr(cyc + 1, 0, FILLER);
      if (k == 30) expect_wr(cyc + 1, 1, FILLER);
      step();
      step();
    end
    stop = 1'b1;
    expect_wr(cyc + 2, 2, END_MARKER);
    step();
    for (int i = 0; i < 8 && sb.size() != 0; i++) step();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL filler_drain: %0d writes missing, required 0", sb.size());
      sb.delete();
    end
    tests++;
    if (len !== 8'd3 || done !== 1'b1) begin
      fails++;
      $display("FAIL filler_len: got len %0d done %b, required 3 1", len, done);
    end
  endtask

  task automatic test_multi_lane();
    start = 1'b1;
    step();
    arrows = 4'b0010;
    step();
    arrows = 4'b1010;
    tick = 1'b1;
    expect_wr(cyc + 1, 0, 8'hA1);
    step();
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      step();
      step();
    end
    arrows = 4'b1110;
    tick = 1'b1;
    expect_wr(cyc + 1, 1, 8'h44);
    step();
    stop = 1'b1;
    expect_wr(cyc + 2, 2, END_MARKER);
    step();
    arrows = 4'h0;
    for (int i = 0; i < 8 && sb.size() != 0; i++) step();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL multi_drain: %0d writes missing, required 0", sb.size());
      sb.delete();
    end
    tests++;
    if (len !== 8'd3) begin
      fails++;
      $display("FAIL multi_len: got %0d, required 3", len);
    end
  endtask

  task automatic test_full();
    start = 1'b1;
    step();
    for (int i = 0; i < 127; i++) begin
      arrows = 4'h0;
      step();
      arrows = 4'h1;
      tick = 1'b1;
      expect_wr(cyc + 1, i, 8'h11);
      if (i == 126) expect_wr(cyc + 3, 127, END_MARKER);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      arrows = i[0] ? 4'h2 : 4'h0;
      tick = 1'b1;
      step();
    end
    arrows = 4'h0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL full_drain: %0d writes missing, required 0", sb.size());
      sb.delete();
    end
    tests++;
    if (len !== 8'd128 || done !== 1'b1) begin
      fails++;
      $display("FAIL full_len: got len %0d done %b, required 128 1", len, done);
    end
  endtask

  task automatic test_stop_tick();
    arrows = 4'b1000;
    start = 1'b1;
    step();
    step();
    arrows = 4'b1100;
    tick = 1'b1;
    stop = 1'b1;
    expect_wr(cyc + 1, 0, 8'h41);
    expect_wr(cyc + 2, 1, END_MARKER);
    step();
    arrows = 4'h0;
    for (int i = 0; i < 8 && sb.size() != 0; i++) step();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL stop_tick_drain: %0d writes missing, required 0", sb.size());
      sb.delete();
    end
    tests++;
    if (len !== 8'd2 || done !== 1'b1) begin
      fails++;
      $display("FAIL stop_tick_len: got len %0d done %b, required 2 1", len, done);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      arrows = 4'h0;
      step();
      arrows = 4'h1;
      tick = 1'b1;
      expect_wr(cyc + 1, i, 8'h11);
      step();
    end
    arrows = 4'h0;
    step();
    arrows = 4'h4;
    step();
    reset_n = 1'b0;
    step();
    tests++;
    if ({wr_en, wr_addr, wr_data, len, busy, done} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: got en %b addr %0d data %02h len %0d busy %b done %b, required all 0",
               wr_en, wr_addr, wr_data, len, busy, done);
    end
    reset_n = 1'b1;
    arrows = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      stop = 1'b1;
      step();
    end
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sb.size() != 0) begin
      fails++;
      $display("FAIL midreset_idle: got busy %b done %b pending %0d, required 0 0 0",
               busy, done, sb.size());
      sb.delete();
    end
    start = 1'b1;
    step();
    arrows = 4'h1;
    tick = 1'b1;
    expect_wr(cyc + 1, 0, 8'h11);
    step();
    arrows = 4'h0;
    start = 1'b1;
    step();
    arrows = 4'h1;
    tick = 1'b1;
    expect_wr(cyc + 1, 1, 8'h11);
    step();
    stop = 1'b1;
    expect_wr(cyc + 2, 2, END_MARKER);
    step();
    arrows = 4'h0;
    for (int i = 0; i < 8 && sb.size() != 0; i++) step();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL restart_drain: %0d writes missing, required 0", sb.size());
      sb.delete();
    end
    stop = 1'b1;
    tick = 1'b1;
    step();
    step();
    tests++;
    if (len !== 8'd3 || done !== 1'b1) begin
      fails++;
      $display("FAIL done_hold: got len %0d done %b, required 3 1", len, done);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_filler();
    test_multi_lane();
    test_full();
    test_stop_tick();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
